// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared widths, reset PC, NOP encoding and the queued {pc, insn} entry type
package fetch_queue_pkg;
  localparam int AWIDTH = 32;
  localparam int DWIDTH = 32;
  localparam int DEF_DEPTH = 2;
  localparam logic [AWIDTH-1:0] DEF_BASEADDR = 32'h0100_0000;
  localparam logic [DWIDTH-1:0] NOP_INSN = 32'h0000_0013;
  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch bus (mem req/resp, redirect, decode handshake); master = fetch_queue, slave = memory/execute/decode
interface fetch_queue_if;
  import fetch_queue_pkg::*;
  logic              req_valid_o;
  logic [AWIDTH-1:0] req_addr_o;
  logic              req_ready_i;
  logic              resp_valid_i;
  logic [DWIDTH-1:0] resp_data_i;
  logic              redirect_i;
  logic [AWIDTH-1:0] redirect_pc_i;
  logic              insn_valid_o;
  logic              insn_ready_i;
  logic [AWIDTH-1:0] pc_o;
  logic [DWIDTH-1:0] insn_o;
  modport master (
    output req_valid_o, req_addr_o, insn_valid_o, pc_o, insn_o,
    input  req_ready_i, resp_valid_i, resp_data_i, redirect_i, redirect_pc_i, insn_ready_i
  );
  modport slave (
    input  req_valid_o, req_addr_o, insn_valid_o, pc_o, insn_o,
    output req_ready_i, resp_valid_i, resp_data_i, redirect_i, redirect_pc_i, insn_ready_i
  );
endinterface

// File: rtl/fetch_queue_fifo_sync.sv
// fifo_sync: DEPTH-entry synchronous fifo; ports clk, rst, flush, push/din, pop/dout, full, empty, count
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == CW'(DEPTH);
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_comb begin
    wr_d = flush ? '0 : do_push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
    rd_d = flush ? '0 : do_pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
    cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
    if (do_push && !flush) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: owns the PC, issues credit-limited word fetches, queues {pc, insn} for decode, flushes on redirect; ports clk, rst, bus (fetch_queue_if.master)
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [AWIDTH-1:0] BASEADDR = DEF_BASEADDR
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AWIDTH-1:0] pc_q, pc_d, pend_pc;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, q_count, p_count;
  logic fire, take, drop, deq, q_full, q_empty, p_full, p_empty;
  fetch_entry_t head;
  assign bus.req_valid_o = !rst && !bus.redirect_i && ({1'b0, q_count} + {1'b0, out_q}) < (CW + 1)'(DEPTH);
  assign bus.req_addr_o = pc_q;
  assign fire = bus.req_valid_o && bus.req_ready_i;
  assign take = bus.resp_valid_i && !bus.redirect_i && disc_q == '0 && out_q != '0;
  assign drop = bus.resp_valid_i && !bus.redirect_i && disc_q != '0;
  assign bus.insn_valid_o = !rst && !q_empty && !bus.redirect_i;
  assign deq = bus.insn_valid_o && bus.insn_ready_i;
  assign bus.pc_o = bus.insn_valid_o ? head.pc : '0;
  assign bus.insn_o = bus.insn_valid_o ? head.insn : NOP_INSN;
  always_comb begin
    pc_d = bus.redirect_i ? bus.redirect_pc_i & ~AWIDTH'(3) : fire ? pc_q + AWIDTH'(4) : pc_q;
    out_d = bus.redirect_i ? '0 : out_q + CW'(fire) - CW'(take);
    disc_d = bus.redirect_i ? disc_q + out_q - CW'(bus.resp_valid_i && (disc_q != '0 || out_q != '0))
                            : disc_q - CW'(drop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= BASEADDR;
      out_q <= '0;
      disc_q <= '0;
    end else begin
      pc_q <= pc_d;
      out_q <= out_d;
      disc_q <= disc_d;
    end
  end
  fifo_sync #(.WIDTH(AWIDTH), .DEPTH(DEPTH)) u_pend (
    .clk(clk), .rst(rst), .flush(bus.redirect_i), .push(fire), .din(pc_q), .pop(take),
    .dout(pend_pc), .full(p_full), .empty(p_empty), .count(p_count)
  );
  fifo_sync #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_queue (
    .clk(clk), .rst(rst), .flush(bus.redirect_i), .push(take), .din({pend_pc, bus.resp_data_i}), .pop(deq),
    .dout(head), .full(q_full), .empty(q_empty), .count(q_count)
  );
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst) !(bus.resp_valid_i && out_q == '0 && disc_q == '0));
  a_pend_tracks: assert property (@(posedge clk) disable iff (rst) p_count == out_q);
  a_pend_space: assert property (@(posedge clk) disable iff (rst) !(fire && p_full) && !(take && p_empty));
  a_queue_space: assert property (@(posedge clk) disable iff (rst) !(take && q_full && !deq));
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scoreboard bench for fetch_queue with an in-order variable-latency memory model
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  localparam int DEPTH = 2;
  localparam logic [31:0] BASE = 32'h0100_0000;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  fetch_queue_if bus();
  fetch_queue #(.DEPTH(DEPTH), .BASEADDR(BASE)) dut (.clk(clk), .rst(rst), .bus(bus));
  int vec = 0, err = 0, cyc = 0, lat = 1, out_n = 0, n = 0;
  logic [31:0] mq_addr[$];
  int mq_due[$];
  logic [31:0] sb[$];
  logic [31:0] acc_log[$];
  logic [31:0] exp_addr = BASE;
  logic [31:0] first_pc = 0;
  logic want_first = 0;
  logic hit;
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic step(input int mode, input logic [31:0] rpc, output logic h);
    logic [31:0] p;
    bus.resp_valid_i = mq_addr.size() > 0 && mq_due[0] <= cyc;
    bus.resp_data_i = bus.resp_valid_i ? mdata(mq_addr[0]) : 32'h0;
    bus.redirect_pc_i = rpc;
    bus.redirect_i = 0;
    #1;
    h = mode == 1 || (mode == 2 && bus.insn_valid_o && bus.resp_valid_i);
    bus.redirect_i = h;
    #1;
    if (rst) begin
      chk("rst_req_valid", bus.req_valid_o, 0);
      chk("rst_insn_valid", bus.insn_valid_o, 0);
      chk("rst_pc", bus.pc_o, 0);
      chk("rst_insn", bus.insn_o, NOP_INSN);
    end
    if (h) begin
      chk("redir_insn_valid", bus.insn_valid_o, 0);
      chk("redir_req_valid", bus.req_valid_o, 0);
    end
    if (bus.req_valid_o) chk("req_addr", bus.req_addr_o, exp_addr);
    if (bus.insn_valid_o && bus.insn_ready_i) begin
      vec++;
      assert (sb.size() > 0) else begin
        err++;
        $error("FAIL unexpected_out observed pc=%h expected no output", bus.pc_o);
      end
      if (sb.size() > 0) begin
        p = sb.pop_front();
        chk("out_pc", bus.pc_o, p);
        chk("out_insn", bus.insn_o, mdata(p));
      end
      if (want_first) begin
        first_pc = bus.pc_o;
        want_first = 0;
      end
      out_n++;
    end
    if (bus.req_valid_o && bus.req_ready_i) begin
      mq_addr.push_back(bus.req_addr_o);
      mq_due.push_back(cyc + lat);
      sb.push_back(exp_addr);
      acc_log.push_back(bus.req_addr_o);
      exp_addr = exp_addr + 32'd4;
    end
    if (bus.resp_valid_i) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (h) begin
      sb.delete();
      exp_addr = rpc & ~32'h3;
      want_first = 1;
    end
    if (rst) begin
      sb.delete();
      exp_addr = BASE;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  initial begin
    bus.req_ready_i = 1;
    bus.insn_ready_i = 1;
    bus.resp_valid_i = 0;
    bus.resp_data_i = 0;
    bus.redirect_i = 0;
    bus.redirect_pc_i = 0;
    repeat (2) step(0, 0, hit);
    rst = 0;
    repeat (12) step(0, 0, hit);
    chk("t1_first_req", acc_log[0], BASE);
    chk("t1_third_req", acc_log[2], BASE + 32'd8);
    chk("t1_progress", out_n > 4, 1);
    bus.insn_ready_i = 0;
    repeat (10) step(0, 0, hit);
    chk("t2_inflight_depth", sb.size(), DEPTH);
    chk("t2_req_stopped", bus.req_valid_o, 0);
    chk("t2_head_valid", bus.insn_valid_o, 1);
    chk("t2_head_pc", bus.pc_o, sb[0]);
    chk("t2_head_insn", bus.insn_o, mdata(sb[0]));
    bus.insn_ready_i = 1;
    repeat (8) step(0, 0, hit);
    bus.req_ready_i = 0;
    repeat (3) step(0, 0, hit);
    chk("t3_req_valid", bus.req_valid_o, 1);
    chk("t3_req_hold", bus.req_addr_o, exp_addr);
    bus.req_ready_i = 1;
    repeat (6) step(0, 0, hit);
    lat = 3;
    n = 0;
    while (mq_addr.size() < 2 && n < 20) begin
      step(0, 0, hit);
      n++;
    end
    chk("t4_two_inflight", mq_addr.size(), 2);
    first_pc = 0;
    step(1, 32'h0100_0103, hit);
    acc_log.delete();
    repeat (12) step(0, 0, hit);
    chk("t4_next_req", acc_log[0], 32'h0100_0100);
    chk("t4_first_out", first_pc, 32'h0100_0100);
    lat = 1;
    n = 0;
    hit = 0;
    while (!hit && n < 30) begin
      step(2, 32'h0100_0200, hit);
      n++;
    end
    chk("t5_redirect_hit", hit, 1);
    repeat (10) step(0, 0, hit);
    step(1, 32'hFFFF_FFFE, hit);
    acc_log.delete();
    repeat (6) step(0, 0, hit);
    chk("t6_wrap_top", acc_log[0], 32'hFFFF_FFFC);
    chk("t6_wrap_zero", acc_log[1], 32'h0000_0000);
    lat = 2;
    repeat (3) step(0, 0, hit);
    rst = 1;
    repeat (2) step(0, 0, hit);
    rst = 0;
    mq_addr.delete();
    mq_due.delete();
    acc_log.delete();
    repeat (8) step(0, 0, hit);
    chk("t6_post_rst_req", acc_log[0], BASE);
    chk("t6_post_rst_req2", acc_log[1], BASE + 32'd4);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
